card7seg_bank: RTL and testbench

//  Parametrised multi-digit card/score display bank for the Baccarat table.

---
 rtl/card7seg_bank.sv | 138 +++++++++++++
 tb/tb_card7seg_bank.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/card7seg_bank.sv
// Multi-digit card/score display bank: per-digit value registers, blink-on-load
// sequencing and active-low 7-segment decode for the HEX displays.
module card7seg_bank #(
  parameter int NUM_DIGITS  = 6,
  parameter int BLINK_HALF  = 4,
  parameter int BLINK_COUNT = 3,
  localparam int IDXW       = $clog2(NUM_DIGITS)
) (
  input  logic                    slow_clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [IDXW-1:0]         load_idx,
  input  logic [3:0]              load_val,
  input  logic                    load_mode,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   loaded
);

  localparam int TOTAL = 2 * BLINK_HALF * BLINK_COUNT;
  localparam int CW    = $clog2(TOTAL);
  localparam int HW    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(TOTAL - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_HALF - 1);
  localparam logic [6:0]    BLANK     = 7'h7F;

  typedef enum logic [1:0] {ST_EMPTY, ST_BLINK, ST_SHOW} digit_state_t;

  // Mode 0 = card rank (A..K, 10 drawn as "0"), mode 1 = decimal score 0..9.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic m);
    logic [6:0] seg;
    seg = BLANK;
    case (v)
      4'd0:  seg = m ? 7'b1000000 : BLANK;
      4'd1:  seg = m ? 7'b1111001 : 7'b0001000;
      4'd2:  seg = 7'b0100100;
      4'd3:  seg = 7'b0110000;
      4'd4:  seg = 7'b0011001;
      4'd5:  seg = 7'b0010010;
      4'd6:  seg = 7'b0000010;
      4'd7:  seg = 7'b1111000;
      4'd8:  seg = 7'b0000000;
      4'd9:  seg = 7'b0010000;
      4'd10: seg = m ? BLANK : 7'b1000000;
      4'd11: seg = m ? BLANK : 7'b1100001;
      4'd12: seg = m ? BLANK : 7'b0011000;
      4'd13: seg = m ? BLANK : 7'b0001001;
      default: seg = BLANK;
    endcase
    return seg;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      digit_state_t  state_reg, state_next;
      logic [3:0]    value_reg;
      logic          mode_reg;
      logic [CW-1:0] blink_cnt_reg, blink_cnt_next;
      logic [HW-1:0] half_cnt_reg, half_cnt_next;
      logic          phase_reg, phase_next;
      logic [6:0]    hex_reg, hex_next;
      logic          hit;

      assign hit = load && (load_idx == IDXW'(gi));

      always_ff @(posedge slow_clock) begin
        if (reset) begin
          state_reg     <= ST_EMPTY;
          value_reg     <= 4'd0;
          mode_reg      <= 1'b0;
          blink_cnt_reg <= '0;
          half_cnt_reg  <= '0;
          phase_reg     <= 1'b0;
          hex_reg       <= BLANK;
        end else begin
          state_reg     <= state_next;
          blink_cnt_reg <= blink_cnt_next;
          half_cnt_reg  <= half_cnt_next;
          phase_reg     <= phase_next;
          hex_reg       <= hex_next;
          if (hit && !clear) begin
            value_reg <= load_val;
            mode_reg  <= load_mode;
          end
        end
      end

      // phase_reg tracks (blink_cnt / BLINK_HALF) odd-ness without a divider.
      always_comb begin
        state_next     = state_reg;
        blink_cnt_next = blink_cnt_reg;
        half_cnt_next  = half_cnt_reg;
        phase_next     = phase_reg;
        if (clear) begin
          state_next     = ST_EMPTY;
          blink_cnt_next = '0;
          half_cnt_next  = '0;
          phase_next     = 1'b0;
        end else if (hit) begin
          state_next     = ST_BLINK;
          blink_cnt_next = '0;
          half_cnt_next  = '0;
          phase_next     = 1'b0;
        end else if (state_reg == ST_BLINK) begin
          if (half_cnt_reg == HALF_LAST) begin
            half_cnt_next = '0;
            phase_next    = ~phase_reg;
          end else begin
            half_cnt_next = half_cnt_reg + 1'b1;
          end
          if (blink_cnt_reg == CNT_LAST) begin
            state_next     = ST_SHOW;
            blink_cnt_next = '0;
            half_cnt_next  = '0;
            phase_next     = 1'b0;
          end else begin
            blink_cnt_next = blink_cnt_reg + 1'b1;
          end
        end
      end

      always_comb begin
        hex_next = BLANK;
        if (!clear) begin
          case (state_reg)
            ST_BLINK: hex_next = phase_reg ? decode(value_reg, mode_reg) : BLANK;
            ST_SHOW:  hex_next = decode(value_reg, mode_reg);
            default:  hex_next = BLANK;
          endcase
        end
      end

      assign hex_out[7*gi +: 7] = hex_reg;
      assign loaded[gi]         = (state_reg != ST_EMPTY);
    end
  endgenerate

endmodule

// File: tb/tb_card7seg_bank.sv
// Self-checking bench for card7seg_bank: directed scenarios plus random traffic
// against a timestamp-based reference model of each digit.
module tb_card7seg_bank;
  localparam int ND = 3;
  localparam int B  = 2;
  localparam int BC = 2;
  localparam int T  = 2 * B * BC;

  logic            slow_clock = 1'b0;
  logic            reset = 1'b1;
  logic            load = 1'b0;
  logic [1:0]      load_idx = 2'd0;
  logic [3:0]      load_val = 4'd0;
  logic            load_mode = 1'b0;
  logic            clear = 1'b0;
  logic [7*ND-1:0] hex_out;
  logic [ND-1:0]   loaded;

  card7seg_bank #(.NUM_DIGITS(ND), .BLINK_HALF(B), .BLINK_COUNT(BC)) dut (
    .slow_clock(slow_clock), .reset(reset), .load(load), .load_idx(load_idx),
    .load_val(load_val), .load_mode(load_mode), .clear(clear),
    .hex_out(hex_out), .loaded(loaded)
  );

  always #5 slow_clock = ~slow_clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: each digit remembers what it holds and the edge it was loaded at.
  bit         m_ld   [ND];
  int         m_val  [ND];
  bit         m_mode [ND];
  int         m_t0   [ND];
  logic [7*ND-1:0] exp_hex;
  logic [ND-1:0]   exp_loaded;

  function automatic logic [6:0] ref_dec(int v, bit mode);
    logic [6:0] card;
    case (v)
      1: card = 7'b0001000;   2: card = 7'b0100100;  3: card = 7'b0110000;
      4: card = 7'b0011001;   5: card = 7'b0010010;  6: card = 7'b0000010;
      7: card = 7'b1111000;   8: card = 7'b0000000;  9: card = 7'b0010000;
      10: card = 7'b1000000;  11: card = 7'b1100001; 12: card = 7'b0011000;
      13: card = 7'b0001001;  default: card = 7'h7F;
    endcase
    if (!mode) return card;
    if (v == 0) return 7'b1000000;
    if (v == 1) return 7'b1111001;
    if (v <= 9) return card;
    return 7'h7F;
  endfunction

  // Display seen right after edge e reflects the digit as it stood after edge e-1.
  function automatic logic [6:0] ref_digit(int d, int e);
    int age;
    if (!m_ld[d]) return 7'h7F;
    age = e - 1 - m_t0[d];
    if (age < T && ((age / B) % 2 == 0)) return 7'h7F;
    return ref_dec(m_val[d], m_mode[d]);
  endfunction

  task automatic tick();
    @(posedge slow_clock);
    cyc++;
    for (int d = 0; d < ND; d++) exp_hex[7*d +: 7] = ref_digit(d, cyc);
    if (reset || clear) begin
      for (int d = 0; d < ND; d++) m_ld[d] = 1'b0;
      exp_hex = '1;
    end else if (load && load_idx < ND) begin
      m_ld[load_idx]   = 1'b1;
      m_val[load_idx]  = load_val;
      m_mode[load_idx] = load_mode;
      m_t0[load_idx]   = cyc;
    end
    for (int d = 0; d < ND; d++) exp_loaded[d] = m_ld[d];
    #1;
  endtask

  task automatic drive_load(int idx, int val, bit mode);
    load = 1'b1; load_idx = 2'(idx); load_val = 4'(val); load_mode = mode;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (hex_out !== 21'h1FFFFF || loaded !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: hex=%h loaded=%b expected hex=1fffff loaded=000", hex_out, loaded);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (hex_out !== 21'h1FFFFF || loaded !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: cyc=%0d hex=%h loaded=%b expected 1fffff/000", cyc, hex_out, loaded);
      end
    end
    $display("test_reset done, cyc=%0d", cyc);
  endtask

  task automatic test_card_blink();
    logic [6:0] want;
    drive_load(1, 12, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      want = ((k >= 1 && k <= 2) || (k >= 5 && k <= 6)) ? 7'h7F : 7'b0011000;
      checks++;
      if (hex_out[13:7] !== want || hex_out[6:0] !== 7'h7F || hex_out[20:14] !== 7'h7F
          || loaded !== 3'b010) begin
        errors++;
        $display("FAIL card_blink: t+%0d hex=%h loaded=%b expected digit1=%b others blank loaded=010",
                 k, hex_out, loaded, want);
      end
    end
    $display("test_card_blink done, cyc=%0d", cyc);
  endtask

  task automatic test_score_invalid();
    drive_load(0, 7, 1'b1);
    tick();
    drive_load(2, 10, 1'b1);
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (hex_out !== exp_hex || loaded !== exp_loaded) begin
        errors++;
        $display("FAIL score_model: cyc=%0d hex=%h loaded=%b expected hex=%h loaded=%b",
                 cyc, hex_out, loaded, exp_hex, exp_loaded);
      end
    end
    checks++;
    if (hex_out[6:0] !== 7'b1111000 || hex_out[20:14] !== 7'h7F || loaded !== 3'b111) begin
      errors++;
      $display("FAIL score_invalid: hex=%h loaded=%b expected digit0=1111000 digit2 blank loaded=111",
               hex_out, loaded);
    end
    $display("test_score_invalid done, cyc=%0d", cyc);
  endtask

  task automatic test_overwrite();
    logic [6:0] want;
    drive_load(1, 1, 1'b0);
    tick();
    load = 1'b0;
    tick(); tick(); tick();
    drive_load(1, 13, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 5; k <= 13; k++) begin
      tick();
      checks++;
      if (k <= 6 || k >= 11) begin
        want = (k <= 6) ? 7'h7F : 7'b0001001;
        if (hex_out[13:7] !== want) begin
          errors++;
          $display("FAIL overwrite: t+%0d digit1=%b expected %b", k, hex_out[13:7], want);
        end
      end else if (hex_out !== exp_hex) begin
        errors++;
        $display("FAIL overwrite_model: t+%0d hex=%h expected %h", k, hex_out, exp_hex);
      end
    end
    $display("test_overwrite done, cyc=%0d", cyc);
  endtask

  task automatic test_clear();
    drive_load(2, 9, 1'b1);
    tick();
    clear = 1'b1;
    drive_load(0, 5, 1'b0);
    tick();
    clear = 1'b0; load = 1'b0;
    tick();
    checks++;
    if (hex_out !== 21'h1FFFFF || loaded !== 3'b000) begin
      errors++;
      $display("FAIL clear_beats_load: hex=%h loaded=%b expected 1fffff/000", hex_out, loaded);
    end
    drive_load(0, 8, 1'b0);
    tick();
    load = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (hex_out !== 21'h1FFFFF || loaded !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_blink: hex=%h loaded=%b expected 1fffff/000", hex_out, loaded);
    end
    $display("test_clear done, cyc=%0d", cyc);
  endtask

  task automatic test_out_of_range();
    drive_load(0, 3, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 0; k < T + 2; k++) tick();
    drive_load(3, 5, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (hex_out !== {7'h7F, 7'h7F, 7'b0110000} || loaded !== 3'b001) begin
        errors++;
        $display("FAIL out_of_range: k=%0d hex=%h loaded=%b expected %h/001",
                 k, hex_out, loaded, {7'h7F, 7'h7F, 7'b0110000});
      end
    end
    $display("test_out_of_range done, cyc=%0d", cyc);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      clear = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 1) == 1);
      load_idx  = 2'($urandom_range(0, 3));
      load_val  = 4'($urandom_range(0, 15));
      load_mode = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (hex_out !== exp_hex || loaded !== exp_loaded) begin
        errors++;
        $display("FAIL random: cyc=%0d hex=%h loaded=%b expected hex=%h loaded=%b",
                 cyc, hex_out, loaded, exp_hex, exp_loaded);
      end
    end
    reset = 1'b0; clear = 1'b0; load = 1'b0;
    $display("test_random done, cyc=%0d", cyc);
  endtask

  initial begin
    test_reset();
    test_card_blink();
    test_score_invalid();
    test_overwrite();
    test_clear();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
